// File: rtl/cpu_pkg.sv
// cpu_pkg: shared writeback-select encodings, control-bundle bit positions and halt FSM states
package cpu_pkg;
  localparam logic [2:0] WB_SRC_ALU  = 3'd0;
  localparam logic [2:0] WB_SRC_MEM  = 3'd1;
  localparam logic [2:0] WB_SRC_LINK = 3'd2;
  localparam logic [2:0] WB_SRC_IMM  = 3'd3;
  localparam logic [2:0] WB_SRC_COND = 3'd4;
  localparam int WB_DST_LSB = 0;
  localparam int WB_SRC_LSB = 3;
  localparam int WB_REGWR   = 6;
  localparam int MEM_EN   = 0;
  localparam int MEM_WR   = 1;
  localparam int MEM_HALT = 2;
  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } halt_state_e;
  function automatic logic wb_src_legal(input logic [2:0] sel);
    return sel <= WB_SRC_COND;
  endfunction
endpackage

// File: rtl/wb_src_mux.sv
// wb_src_mux: combinational writeback-source select with illegal-encoding flag
module wb_src_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        i_sel,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_mem,
  input  logic [DATA_W-1:0] i_link,
  input  logic [DATA_W-1:0] i_imm,
  input  logic              i_cond,
  output logic [DATA_W-1:0] o_data,
  output logic              o_legal
);
  // select one of five sources; illegal encodings yield zero data
  always_comb begin
    o_legal = wb_src_legal(i_sel);
    o_data  = i_sel == WB_SRC_ALU  ? i_alu  :
              i_sel == WB_SRC_MEM  ? i_mem  :
              i_sel == WB_SRC_LINK ? i_link :
              i_sel == WB_SRC_IMM  ? i_imm  :
              i_sel == WB_SRC_COND ? {{(DATA_W-1){1'b0}}, i_cond} : '0;
  end
endmodule

// File: rtl/memwb_writeback.sv
// memwb_writeback: MEM/WB register, writeback select and halt drain/freeze; WB_RETIRE_CNT_EN adds retire_cnt
module memwb_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]       retire_cnt,
`endif
  input  logic              in_valid,
  input  logic [7:0]        in_wb_ctrl,
  input  logic              in_halt,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_link,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_cond,
  input  logic              stall,
  input  logic              flush,
  output logic [REG_AW-1:0] wb_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en,
  output logic              halt_done,
  output logic              err
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic [2:0]        src;
    logic              we;
    logic              halt;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] link;
    logic [DATA_W-1:0] imm;
    logic              cond;
  } slot_t;
  slot_t       r_slot;
  slot_t       w_in;
  halt_state_e r_state;
  logic        w_run;
  logic        w_legal;
  logic        w_halt_fire;
  logic        w_retire;
  assign w_in = '{
    valid: in_valid,
    dst:   in_wb_ctrl[WB_DST_LSB +: REG_AW],
    src:   in_wb_ctrl[WB_SRC_LSB +: 3],
    we:    in_wb_ctrl[WB_REGWR],
    halt:  in_halt,
    alu:   in_alu,
    mem:   in_mem,
    link:  in_link,
    imm:   in_imm,
    cond:  in_cond
  };
  assign w_run       = r_state == ST_RUN;
  assign w_retire    = r_slot.valid & w_run & ~stall;
  assign w_halt_fire = w_retire & r_slot.halt;
  wb_src_mux #(.DATA_W(DATA_W)) u_mux (
    .i_sel   (r_slot.src),
    .i_alu   (r_slot.alu),
    .i_mem   (r_slot.mem),
    .i_link  (r_slot.link),
    .i_imm   (r_slot.imm),
    .i_cond  (r_slot.cond),
    .o_data  (wb_data),
    .o_legal (w_legal)
  );
  // pipeline register and halt FSM; once halted everything freezes until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot  <= '0;
      r_state <= ST_RUN;
    end else if (w_run) begin
      if (w_halt_fire) r_state <= ST_HALTED;
      if (flush) r_slot <= '0;
      else if (!stall) r_slot <= w_in;
    end
  end
  // writeback handshake derived purely from the registered slot
  always_comb begin
    wb_dst    = r_slot.dst;
    wb_en     = r_slot.valid & r_slot.we & w_run & w_legal;
    err       = r_slot.valid & r_slot.we & w_run & ~w_legal;
    halt_done = ~w_run | (r_slot.valid & r_slot.halt);
  end
`ifdef WB_RETIRE_CNT_EN
  // saturating count of instructions leaving WB while running
  always_ff @(posedge clk) begin
    if (rst) retire_cnt <= '0;
    else if (w_retire && retire_cnt != '1) retire_cnt <= retire_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_memwb_writeback.sv
// tb_memwb_writeback: directed plan plus randomized traffic against a behavioural slot model
module tb_memwb_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_wb_ctrl;
  logic        in_halt;
  logic [15:0] in_alu, in_mem, in_link, in_imm;
  logic        in_cond;
  logic        stall, flush;
  logic [2:0]  wb_dst;
  logic [15:0] wb_data;
  logic        wb_en, halt_done, err;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memwb_writeback dut (
    .clk(clk), .rst(rst),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .in_valid(in_valid), .in_wb_ctrl(in_wb_ctrl), .in_halt(in_halt),
    .in_alu(in_alu), .in_mem(in_mem), .in_link(in_link), .in_imm(in_imm),
    .in_cond(in_cond), .stall(stall), .flush(flush),
    .wb_dst(wb_dst), .wb_data(wb_data), .wb_en(wb_en),
    .halt_done(halt_done), .err(err)
  );

  // model: the instruction currently sitting in WB, plus halted flag and retire count
  bit          m_valid, m_we, m_halt, m_cond, m_halted;
  logic [2:0]  m_dst, m_src;
  logic [15:0] m_alu, m_mem, m_link, m_imm;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] src_data();
    case (m_src)
      3'd0: return m_alu;
      3'd1: return m_mem;
      3'd2: return m_link;
      3'd3: return m_imm;
      3'd4: return {15'd0, m_cond};
      default: return 16'd0;
    endcase
  endfunction

  task automatic clear_slot();
    {m_valid, m_we, m_halt, m_cond} = '0;
    {m_dst, m_src} = '0;
    {m_alu, m_mem, m_link, m_imm} = '0;
  endtask

  task automatic tick();
    bit going_halt;
    @(posedge clk);
    if (rst) begin
      clear_slot();
      m_halted = 0;
      m_cnt = 0;
    end else if (!m_halted) begin
      going_halt = m_valid && m_halt && !stall;
      if (m_valid && !stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (flush) clear_slot();
      else if (!stall) begin
        m_valid = in_valid; m_dst = in_wb_ctrl[2:0]; m_src = in_wb_ctrl[5:3];
        m_we = in_wb_ctrl[6]; m_halt = in_halt; m_alu = in_alu; m_mem = in_mem;
        m_link = in_link; m_imm = in_imm; m_cond = in_cond;
      end
      m_halted = going_halt;
    end
    #1;
    chk("wb_dst", 32'(wb_dst), 32'(m_dst));
    chk("wb_data", 32'(wb_data), 32'(src_data()));
    chk("wb_en", 32'(wb_en), 32'(!m_halted && m_valid && m_we && m_src <= 3'd4));
    chk("err", 32'(err), 32'(!m_halted && m_valid && m_we && m_src > 3'd4));
    chk("halt_done", 32'(halt_done), 32'(m_halted || (m_valid && m_halt)));
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, m_cnt);
`endif
  endtask

  task automatic idle();
    in_valid = 0; in_wb_ctrl = 0; in_halt = 0; in_cond = 0;
    in_alu = 0; in_mem = 0; in_link = 0; in_imm = 0;
    stall = 0; flush = 0;
  endtask

  function automatic logic [7:0] ctrl(input bit we, input logic [2:0] src, input logic [2:0] dst);
    return {1'b0, we, src, dst};
  endfunction

  initial begin
    rst = 1; idle(); clear_slot(); m_halted = 0; m_cnt = 0;
    tick(); tick();
    chk("rst_en", 32'(wb_en), 0);
    chk("rst_halt_done", 32'(halt_done), 0);
    rst = 0;
    in_valid = 1; in_wb_ctrl = ctrl(1, 3'd0, 3'd3); in_alu = 16'hBEEF;
    tick();
    chk("alu_data", 32'(wb_data), 32'hBEEF);
    chk("alu_dst", 32'(wb_dst), 3);
    chk("alu_en", 32'(wb_en), 1);
    in_wb_ctrl = ctrl(1, 3'd1, 3'd1); in_mem = 16'h1234; tick(); chk("mem_data", 32'(wb_data), 32'h1234);
    in_wb_ctrl = ctrl(1, 3'd2, 3'd7); in_link = 16'h0042; tick(); chk("link_data", 32'(wb_data), 32'h0042);
    in_wb_ctrl = ctrl(1, 3'd3, 3'd2); in_imm = 16'hFF80; tick(); chk("imm_data", 32'(wb_data), 32'hFF80);
    in_wb_ctrl = ctrl(1, 3'd4, 3'd4); in_cond = 1; tick(); chk("cond_data", 32'(wb_data), 32'h0001);
    in_wb_ctrl = ctrl(1, 3'd6, 3'd1); tick();
    chk("illegal_err", 32'(err), 1);
    chk("illegal_en", 32'(wb_en), 0);
    in_wb_ctrl = ctrl(0, 3'd6, 3'd1); tick();
    chk("illegal_nowr_err", 32'(err), 0);
    in_wb_ctrl = ctrl(1, 3'd0, 3'd5); in_alu = 16'h00AA; tick();
    stall = 1; in_alu = 16'h5555; in_wb_ctrl = ctrl(1, 3'd0, 3'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_en", 32'(wb_en), 1);
      chk("stall_data", 32'(wb_data), 32'h00AA);
      chk("stall_dst", 32'(wb_dst), 5);
    end
    flush = 1; tick();
    chk("flush_en", 32'(wb_en), 0);
    flush = 0; stall = 0;
    in_wb_ctrl = ctrl(0, 3'd0, 3'd0); in_halt = 1; tick();
    chk("halt_now", 32'(halt_done), 1);
    in_halt = 0; in_wb_ctrl = ctrl(1, 3'd0, 3'd6); in_alu = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halted_done", 32'(halt_done), 1);
      chk("halted_en", 32'(wb_en), 0);
    end
    rst = 1; tick(); rst = 0;
    chk("unhalt_done", 32'(halt_done), 0);
    tick();
    chk("resume_en", 32'(wb_en), 1);
    chk("resume_data", 32'(wb_data), 32'h7777);
    rst = 1; idle(); tick(); rst = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_wb_ctrl = ctrl(1, 3'd0, 3'(i)); in_alu = 16'(i); tick();
    end
    in_valid = 0; tick(); tick();
    stall = 1; tick(); tick(); tick(); stall = 0;
    in_valid = 1; in_halt = 1; in_wb_ctrl = 0; tick();
    in_valid = 0; in_halt = 0; tick(); tick(); tick();
`ifdef WB_RETIRE_CNT_EN
    chk("retire_total", retire_cnt, 32'd11);
`endif
    chk("retire_halted", 32'(halt_done), 1);
    for (int i = 0; i < 600; i++) begin
      rst        = m_halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 49) == 0);
      in_valid   = $urandom_range(0, 3) != 0;
      in_wb_ctrl = 8'($urandom);
      in_halt    = $urandom_range(0, 24) == 0;
      in_alu     = 16'($urandom); in_mem = 16'($urandom);
      in_link    = 16'($urandom); in_imm = 16'($urandom);
      in_cond    = 1'($urandom);
      stall      = $urandom_range(0, 4) == 0;
      flush      = $urandom_range(0, 11) == 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
